// File: rtl/pipe_arb_pkg.sv
// Shared definitions for the pipelined round-robin arbiter.
//
// Contents:
//   NREQ_DEF, IDW_DEF, DW_DEF  default requester count, grant-id width, payload width
//   rr_mask(ptr)               bit i set for every requester index strictly above ptr
//   onehot2idx(oh)             converts a one-hot vector (up to 8 bits) to its index
//
// The payload width defaults to the DATAWIDTH macro when the build provides it.
// Otherwise it falls back to 32.

`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

package pipe_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int IDW_DEF  = 3;
    localparam int DW_DEF   = `DATAWIDTH;

    // Requesters that come after ptr in rotation order, before the wrap back to 0.
    function automatic logic [7:0] rr_mask(input logic [2:0] ptr);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i > int'(ptr));
        end
        return m;
    endfunction

    function automatic logic [2:0] onehot2idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//
// Ports:
//   req  in   NREQ  request vector
//   ptr  in   IDW   index of the last winner; the search starts at ptr+1 and wraps
//   gnt  out  NREQ  one-hot grant (zero when req is zero)
//   idx  out  IDW   index of the granted bit
//   any  out  1     at least one request is present

module rr_pick
    import pipe_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [7:0] req8;
    logic [7:0] hi;
    logic [7:0] cand;
    logic [7:0] oh;

    // Prefer requests above ptr. If none exist, the wrapped search is just the
    // lowest set bit of the full vector. That case also covers ptr itself, which
    // is checked last.
    always_comb begin
        req8 = 8'(req);
        hi   = req8 & rr_mask(3'(ptr));
        cand = (hi != 8'd0) ? hi : req8;
        oh   = cand & (~cand + 8'd1);
        gnt  = oh[NREQ-1:0];
        idx  = IDW'(onehot2idx(oh));
        any  = |req;
    end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// pipe_rr_arbiter: shares one pipeline-stage input among NREQ requesters using
// round-robin arbitration. One output register slot holds the granted beat.
//
// Ports:
//   clk        in   1        clock, posedge
//   rst_n      in   1        synchronous active-low reset
//   flush      in   1        drop the held beat and accept nothing this cycle
//   req_valid  in   NREQ     per-requester valid
//   req_data   in   NREQ*DW  packed payloads; requester i at [i*DW +: DW]
//   req_lock   in   NREQ     (only with PIPE_ARB_LOCK_EN) keep the grant on this requester
//   req_allow  out  NREQ     per-requester allow, one-hot or zero
//   out_valid  out  1        held beat valid
//   out_data   out  DW       held payload
//   out_id     out  IDW      requester that supplied the held beat
//   out_allow  in   1        downstream takes the held beat this cycle
//
// Build option: define PIPE_ARB_LOCK_EN to add req_lock and locked re-grant.

module pipe_rr_arbiter
    import pipe_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int IDW  = IDW_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*DW-1:0] req_data,
`ifdef PIPE_ARB_LOCK_EN
    input  logic [NREQ-1:0]   req_lock,
`endif
    output logic [NREQ-1:0]   req_allow,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    output logic [IDW-1:0]    out_id,
    input  logic              out_allow
);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] eff_req;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_any;
    logic            slot_free;
    logic            grant_en;
    logic            transfer;
    logic [DW-1:0]   sel_data;

`ifdef PIPE_ARB_LOCK_EN
    logic            locked;

    // While locked, ptr still names the last winner, so it doubles as the lock owner.
    always_comb begin
        eff_req = req_valid;
        if (locked) begin
            eff_req = req_valid & (NREQ'(1) << ptr);
        end
    end
`else
    always_comb begin
        eff_req = req_valid;
    end
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req  (eff_req),
        .ptr  (ptr),
        .gnt  (gnt),
        .idx  (gnt_idx),
        .any  (gnt_any)
    );

    // The slot can take a new beat when it is empty or is being drained this cycle.
    // This gives back-to-back throughput with no bubble.
    always_comb begin
        slot_free = !out_valid || out_allow;
        grant_en  = slot_free && !flush;
        req_allow = grant_en ? gnt : '0;
        transfer  = grant_en && gnt_any;
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Flush wins over out_allow. ptr only moves on an actual transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            ptr       <= IDW'(NREQ - 1);
`ifdef PIPE_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
`ifdef PIPE_ARB_LOCK_EN
            locked    <= 1'b0;
`endif
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_id    <= gnt_idx;
            ptr       <= gnt_idx;
`ifdef PIPE_ARB_LOCK_EN
            locked    <= req_lock[gnt_idx];
`endif
        end else if (out_allow) begin
            out_valid <= 1'b0;
        end
    end

    // The payload register has no reset; out_valid qualifies it.
    always_ff @(posedge clk) begin
        if (rst_n && transfer) begin
            out_data <= sel_data;
        end
    end

endmodule
